// File: rtl/ssm_bitpack_if.sv
// ssm_bitpack_if
// Bundles the syntax-element input handshake, the 128-bit word output
// handshake and the flush/status signals of the substream bit packer.
//
//   se_vld/se_rdy/se_data/se_len : syntax element in, MSB-aligned, 0..128 bits
//   flush / flush_done           : drain request and one-cycle completion pulse
//   word_vld/word_rdy/word_data  : packed 128-bit words out, first bit at [127]
//   fullness                     : count of valid bits held (0..255)
//   len_err                      : sticky flag for an accepted over-long element
//
// Modports:
//   master : the side that supplies elements and consumes words
//   slave  : the packer itself
interface ssm_bitpack_if;
  logic         se_vld;
  logic         se_rdy;
  logic [127:0] se_data;
  logic [7:0]   se_len;
  logic         flush;
  logic         word_vld;
  logic         word_rdy;
  logic [127:0] word_data;
  logic [7:0]   fullness;
  logic         flush_done;
  logic         len_err;

  modport master (
    output se_vld, se_data, se_len, flush, word_rdy,
    input  se_rdy, word_vld, word_data, fullness, flush_done, len_err
  );

  modport slave (
    input  se_vld, se_data, se_len, flush, word_rdy,
    output se_rdy, word_vld, word_data, fullness, flush_done, len_err
  );
endinterface

// File: rtl/ssm_bitpack.sv
// ssm_bitpack
// Encoder-side substream bit packer. Variable-length syntax elements
// (0..128 bits, MSB-first) are concatenated into a 255-bit accumulator
// whose valid bits always sit at the top. Whenever 128 or more bits are
// held, the top 128 are offered as an output word. A flush drains the
// remainder, padding the last partial word with PAD_BIT.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rstn  : asynchronous active-low reset
//   bus   : ssm_bitpack_if.slave (element in, word out, flush, status)
//
// Parameters:
//   PAD_BIT : fill value for all accumulator bits below the valid region
module ssm_bitpack #(
  parameter logic PAD_BIT = 1'b0
) (
  input logic          clk,
  input logic          rstn,
  ssm_bitpack_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Clamp an element length to the largest legal value.
  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    if (len > 8'd128) begin
      return 8'd128;
    end else begin
      return len;
    end
  endfunction

  // Mask selecting the top 'len' bits of a 128-bit element (len <= 128).
  function automatic logic [127:0] top_mask(input logic [7:0] len);
    return ~({128{1'b1}} >> len);
  endfunction

  // Mask selecting the top 'n' bits of the 255-bit accumulator.
  function automatic logic [254:0] lead_mask(input logic [8:0] n);
    return ~({255{1'b1}} >> n);
  endfunction

  state_t         state_r;
  state_t         state_nxt_s;
  logic [254:0]   acc_r;
  logic [254:0]   acc_nxt_s;
  logic [7:0]     fullness_r;
  logic [7:0]     fullness_nxt_s;
  logic           flush_done_r;
  logic           len_err_r;
  logic           len_err_nxt_s;

  logic           se_rdy_s;
  logic           word_vld_s;
  logic           accept_s;
  logic           pop_s;
  logic           done_s;
  logic [7:0]     eff_len_s;
  logic [127:0]   se_masked_s;
  logic [254:0]   placed_s;
  logic [8:0]     sum_len_s;
  logic [254:0]   keep_s;
  logic [254:0]   valid_nxt_s;

  // Handshake qualifiers derived from registers only.
  always_comb begin
    se_rdy_s   = (fullness_r <= 8'd127) && (state_r == ST_IDLE);
    word_vld_s = (fullness_r >= 8'd128) ||
                 ((state_r == ST_FLUSH) && (fullness_r != 8'd0));
    accept_s   = bus.se_vld && se_rdy_s;
    pop_s      = word_vld_s && bus.word_rdy;
  end

  // Element alignment: mask to its effective length and shift it down to
  // sit directly below the bits already held.
  always_comb begin
    eff_len_s   = clamp_len(bus.se_len);
    se_masked_s = bus.se_data & top_mask(eff_len_s);
    placed_s    = {se_masked_s, 127'b0} >> fullness_r;
    sum_len_s   = {1'b0, fullness_r} + {1'b0, eff_len_s};
    keep_s      = lead_mask({1'b0, fullness_r});
    valid_nxt_s = lead_mask(sum_len_s);
  end

  // Accumulator and fill-level update. Accept and pop never coincide, as
  // accept needs fullness <= 127 in IDLE and pop needs fullness >= 128
  // outside FLUSH; the priority below is therefore arbitrary.
  always_comb begin
    acc_nxt_s      = acc_r;
    fullness_nxt_s = fullness_r;
    if (accept_s) begin
      // Clearing the new region first keeps a PAD_BIT of 1 from leaking
      // into zero-valued element bits.
      acc_nxt_s      = (acc_r & keep_s) | placed_s |
                       ({255{PAD_BIT}} & ~valid_nxt_s);
      fullness_nxt_s = sum_len_s[7:0];
    end else if (pop_s) begin
      acc_nxt_s = {acc_r[126:0], {128{PAD_BIT}}};
      if (fullness_r >= 8'd128) begin
        fullness_nxt_s = fullness_r - 8'd128;
      end else begin
        fullness_nxt_s = 8'd0;
      end
    end else begin
      acc_nxt_s      = acc_r;
      fullness_nxt_s = fullness_r;
    end
  end

  // Sticky length-error flag.
  always_comb begin
    len_err_nxt_s = len_err_r;
    if (accept_s && (bus.se_len > 8'd128)) begin
      len_err_nxt_s = 1'b1;
    end else begin
      len_err_nxt_s = len_err_r;
    end
  end

  // Flush completion: either nothing is held, or this cycle's pop takes
  // the last bits. Completing on the final pop gives flush_done one cycle
  // after that pop instead of two.
  always_comb begin
    done_s = 1'b0;
    if (state_r == ST_FLUSH) begin
      done_s = (fullness_r == 8'd0) || (pop_s && (fullness_r <= 8'd128));
    end else begin
      done_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE/FLUSH controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.flush) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register for the controller.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r        <= {255{PAD_BIT}};
      fullness_r   <= 8'd0;
      flush_done_r <= 1'b0;
      len_err_r    <= 1'b0;
    end else begin
      acc_r        <= acc_nxt_s;
      fullness_r   <= fullness_nxt_s;
      flush_done_r <= done_s;
      len_err_r    <= len_err_nxt_s;
    end
  end

  // Output drive.
  always_comb begin
    bus.se_rdy     = se_rdy_s;
    bus.word_vld   = word_vld_s;
    bus.word_data  = acc_r[254:127];
    bus.fullness   = fullness_r;
    bus.flush_done = flush_done_r;
    bus.len_err    = len_err_r;
  end

endmodule

// File: tb/tb_ssm_bitpack.sv
// tb_ssm_bitpack
// Self-checking bench for ssm_bitpack. A bit-queue model holds the packed
// stream; output words are the first 128 queued bits padded with PAD.
module tb_ssm_bitpack;
  localparam logic PAD = 1'b0;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ssm_bitpack_if bus();

  ssm_bitpack #(.PAD_BIT(PAD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit mq[$];
  bit m_flushing;
  bit m_len_err;
  bit m_done;

  function automatic logic [127:0] m_word();
    logic [127:0] w;
    for (int i = 0; i < 128; i++) begin
      w[127-i] = (i < mq.size()) ? logic'(mq[i]) : PAD;
    end
    return w;
  endfunction

  function automatic logic m_vld();
    return (mq.size() >= 128) || (m_flushing && (mq.size() > 0));
  endfunction

  function automatic logic m_rdy();
    return (mq.size() <= 127) && !m_flushing;
  endfunction

  task automatic idle_inputs();
    bus.se_vld   = 1'b0;
    bus.se_data  = 128'h0;
    bus.se_len   = 8'd0;
    bus.flush    = 1'b0;
    bus.word_rdy = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then clock.
  task automatic cycle();
    bit acc;
    bit pop;
    int len;
    int n;
    acc = bus.se_vld && m_rdy();
    pop = m_vld() && bus.word_rdy;
    if (acc) begin
      len = (bus.se_len > 8'd128) ? 128 : int'(bus.se_len);
      if (bus.se_len > 8'd128) m_len_err = 1'b1;
      for (int i = 0; i < len; i++) mq.push_back(bus.se_data[127-i]);
    end
    if (pop) begin
      n = (mq.size() < 128) ? mq.size() : 128;
      repeat (n) void'(mq.pop_front());
    end
    if (m_flushing) begin
      m_done     = (mq.size() == 0);
      m_flushing = (mq.size() != 0);
    end else begin
      m_done     = 1'b0;
      m_flushing = bus.flush;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    m_flushing = 1'b0;
    m_len_err  = 1'b0;
    m_done     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic [7:0] len);
    bus.se_vld  = 1'b1;
    bus.se_data = d;
    bus.se_len  = len;
    cycle();
    bus.se_vld  = 1'b0;
    bus.se_len  = 8'd0;
  endtask

  // Flush and pop everything, with a bounded wait for flush_done.
  task automatic drain();
    bit seen;
    seen = 1'b0;
    bus.flush = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.word_rdy = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (bus.flush_done === 1'b1) seen = 1'b1;
    end
    bus.word_rdy = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL drain_timeout flush_done=%0b fullness=%0d exp_done=1", bus.flush_done, bus.fullness);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.fullness !== 8'd0) begin bad++; $display("FAIL rst_fullness got=%0d exp=0", bus.fullness); end
    total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL rst_word_vld got=%0b exp=0", bus.word_vld); end
    total++; if (bus.word_data !== {128{PAD}}) begin bad++; $display("FAIL rst_word_data got=%h exp=pad", bus.word_data); end
    total++; if (bus.se_rdy !== 1'b1) begin bad++; $display("FAIL rst_se_rdy got=%0b exp=1", bus.se_rdy); end
    total++; if (bus.flush_done !== 1'b0) begin bad++; $display("FAIL rst_flush_done got=%0b exp=0", bus.flush_done); end
    total++; if (bus.len_err !== 1'b0) begin bad++; $display("FAIL rst_len_err got=%0b exp=0", bus.len_err); end
  endtask

  task automatic test_three48();
    logic [63:0]  t;
    logic [47:0]  a, b, c;
    logic [127:0] exp_w;
    t = {$urandom(), $urandom()}; a = t[47:0];
    t = {$urandom(), $urandom()}; b = t[47:0];
    t = {$urandom(), $urandom()}; c = t[47:0];
    send({a, 80'h0}, 8'd48);
    send({b, 80'hFFFF_FFFF_FFFF_FFFF_FFFF}, 8'd48);
    send({c, 80'h1234_5678_9ABC_DEF0_1357}, 8'd48);
    exp_w = {a, b, c[47:16]};
    total++; if (bus.word_vld !== 1'b1) begin bad++; $display("FAIL abc_vld got=%0b exp=1", bus.word_vld); end
    total++; if (bus.word_data !== exp_w) begin bad++; $display("FAIL abc_word got=%h exp=%h", bus.word_data, exp_w); end
    bus.word_rdy = 1'b1;
    cycle();
    bus.word_rdy = 1'b0;
    total++; if (bus.fullness !== 8'd16) begin bad++; $display("FAIL abc_fullness got=%0d exp=16", bus.fullness); end
    total++; if (bus.word_data[127:112] !== c[15:0]) begin bad++; $display("FAIL abc_tail got=%h exp=%h", bus.word_data[127:112], c[15:0]); end
    total++; if (bus.word_data[111:0] !== {112{PAD}}) begin bad++; $display("FAIL abc_pad got=%h exp=pad", bus.word_data[111:0]); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [127:0] d1, d2, w0;
    d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    d2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(d1, 8'd100);
    send(d2, 8'd100);
    w0 = {d1[127:28], d2[127:100]};
    bus.word_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.word_data !== w0) begin bad++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, bus.word_data, w0); end
      total++; if (bus.se_rdy !== 1'b0) begin bad++; $display("FAIL bp_se_rdy[%0d] got=%0b exp=0", i, bus.se_rdy); end
      total++; if (bus.fullness !== 8'd200) begin bad++; $display("FAIL bp_fullness[%0d] got=%0d exp=200", i, bus.fullness); end
      bus.se_vld  = 1'b1;
      bus.se_data = d1;
      bus.se_len  = 8'd8;
      cycle();
      bus.se_vld  = 1'b0;
    end
    bus.word_rdy = 1'b1;
    cycle();
    bus.word_rdy = 1'b0;
    total++; if (bus.fullness !== 8'd72) begin bad++; $display("FAIL bp_pop_fullness got=%0d exp=72", bus.fullness); end
    total++; if (bus.se_rdy !== 1'b1) begin bad++; $display("FAIL bp_pop_se_rdy got=%0b exp=1", bus.se_rdy); end
    drain();
  endtask

  task automatic test_127_128();
    logic [127:0] d1, d2, exp_w;
    d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    d2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(d1, 8'd127);
    total++; if (bus.se_rdy !== 1'b1) begin bad++; $display("FAIL f127_se_rdy got=%0b exp=1", bus.se_rdy); end
    send(d2, 8'd128);
    exp_w = {d1[127:1], d2[127]};
    total++; if (bus.fullness !== 8'd255) begin bad++; $display("FAIL f255_fullness got=%0d exp=255", bus.fullness); end
    total++; if (bus.word_data !== exp_w) begin bad++; $display("FAIL f255_word got=%h exp=%h", bus.word_data, exp_w); end
    bus.word_rdy = 1'b1;
    cycle();
    bus.word_rdy = 1'b0;
    total++; if (bus.fullness !== 8'd127) begin bad++; $display("FAIL f255_pop_fullness got=%0d exp=127", bus.fullness); end
    total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL f255_pop_vld got=%0b exp=0", bus.word_vld); end
    total++; if (bus.word_data !== {d2[126:0], PAD}) begin bad++; $display("FAIL f255_rest got=%h exp=%h", bus.word_data, {d2[126:0], PAD}); end
    drain();
  endtask

  task automatic test_len5_flush();
    logic [127:0] exp_w;
    int pulses;
    exp_w = {128{PAD}};
    exp_w[127:123] = 5'b11111;
    send({128{1'b1}}, 8'd5);
    total++; if (bus.fullness !== 8'd5) begin bad++; $display("FAIL l5_fullness got=%0d exp=5", bus.fullness); end
    total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL l5_vld_pre got=%0b exp=0", bus.word_vld); end
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    total++; if (bus.word_vld !== 1'b1) begin bad++; $display("FAIL l5_vld got=%0b exp=1", bus.word_vld); end
    total++; if (bus.word_data !== exp_w) begin bad++; $display("FAIL l5_word got=%h exp=%h", bus.word_data, exp_w); end
    bus.word_rdy = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bus.flush_done === 1'b1) pulses++;
    end
    bus.word_rdy = 1'b0;
    total++; if (pulses != 1) begin bad++; $display("FAIL l5_done_pulses got=%0d exp=1", pulses); end
    total++; if (bus.fullness !== 8'd0) begin bad++; $display("FAIL l5_empty got=%0d exp=0", bus.fullness); end
  endtask

  task automatic test_empty_flush();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    total++; if (bus.se_rdy !== 1'b0) begin bad++; $display("FAIL ef_se_rdy got=%0b exp=0", bus.se_rdy); end
    total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL ef_vld got=%0b exp=0", bus.word_vld); end
    cycle();
    total++; if (bus.flush_done !== 1'b1) begin bad++; $display("FAIL ef_done got=%0b exp=1", bus.flush_done); end
    total++; if (bus.se_rdy !== 1'b1) begin bad++; $display("FAIL ef_se_rdy_after got=%0b exp=1", bus.se_rdy); end
    cycle();
    total++; if (bus.flush_done !== 1'b0) begin bad++; $display("FAIL ef_done_once got=%0b exp=0", bus.flush_done); end
  endtask

  task automatic test_len_err();
    logic [127:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    total++; if (bus.len_err !== 1'b0) begin bad++; $display("FAIL le_pre got=%0b exp=0", bus.len_err); end
    send(d, 8'd200);
    total++; if (bus.fullness !== 8'd128) begin bad++; $display("FAIL le_fullness got=%0d exp=128", bus.fullness); end
    total++; if (bus.len_err !== 1'b1) begin bad++; $display("FAIL le_set got=%0b exp=1", bus.len_err); end
    total++; if (bus.word_data !== d) begin bad++; $display("FAIL le_word got=%h exp=%h", bus.word_data, d); end
    drain();
    send(d, 8'd7);
    drain();
    total++; if (bus.len_err !== 1'b1) begin bad++; $display("FAIL le_sticky got=%0b exp=1", bus.len_err); end
  endtask

  task automatic test_reset_mid_flush();
    logic [127:0] d;
    bit seen_done;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(d, 8'd20);
    total++; if (bus.fullness !== 8'd20) begin bad++; $display("FAIL rmf_fullness got=%0d exp=20", bus.fullness); end
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    cycle();
    rstn = 1'b0;
    model_clear();
    #1;
    total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL rmf_vld got=%0b exp=0", bus.word_vld); end
    total++; if (bus.fullness !== 8'd0) begin bad++; $display("FAIL rmf_fullness0 got=%0d exp=0", bus.fullness); end
    total++; if (bus.len_err !== 1'b0) begin bad++; $display("FAIL rmf_len_err got=%0b exp=0", bus.len_err); end
    seen_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.flush_done === 1'b1) seen_done = 1'b1;
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (bus.flush_done === 1'b1) seen_done = 1'b1;
    end
    total++; if (seen_done) begin bad++; $display("FAIL rmf_no_done got=1 exp=0"); end
    total++; if (bus.se_rdy !== 1'b1) begin bad++; $display("FAIL rmf_se_rdy got=%0b exp=1", bus.se_rdy); end
    total++; if (bus.word_vld !== 1'b0) begin bad++; $display("FAIL rmf_vld_after got=%0b exp=0", bus.word_vld); end
  endtask

  task automatic test_random();
    logic [7:0]   ef;
    logic [127:0] ew;
    int r;
    for (int k = 0; k < 800; k++) begin
      ef = 8'(mq.size());
      ew = m_word();
      total++; if (bus.fullness !== ef) begin bad++; $display("FAIL rnd_fullness[%0d] got=%0d exp=%0d", k, bus.fullness, ef); end
      total++; if (bus.word_vld !== m_vld()) begin bad++; $display("FAIL rnd_vld[%0d] got=%0b exp=%0b", k, bus.word_vld, m_vld()); end
      total++; if (bus.se_rdy !== m_rdy()) begin bad++; $display("FAIL rnd_se_rdy[%0d] got=%0b exp=%0b", k, bus.se_rdy, m_rdy()); end
      total++; if (bus.flush_done !== m_done) begin bad++; $display("FAIL rnd_done[%0d] got=%0b exp=%0b", k, bus.flush_done, m_done); end
      total++; if (bus.len_err !== m_len_err) begin bad++; $display("FAIL rnd_len_err[%0d] got=%0b exp=%0b", k, bus.len_err, m_len_err); end
      total++; if (bus.word_data !== ew) begin bad++; $display("FAIL rnd_word[%0d] got=%h exp=%h", k, bus.word_data, ew); end
      bus.se_vld  = ($urandom_range(0, 3) != 0);
      bus.se_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      r = $urandom_range(0, 39);
      if (r == 0)     bus.se_len = 8'($urandom_range(129, 255));
      else if (r < 4) bus.se_len = 8'd0;
      else if (r < 8) bus.se_len = 8'd128;
      else            bus.se_len = 8'($urandom_range(1, 127));
      bus.word_rdy = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle_inputs();
    drain();
    total++; if (bus.fullness !== 8'd0) begin bad++; $display("FAIL rnd_final_fullness got=%0d exp=0", bus.fullness); end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_clear();
    test_reset();
    test_three48();
    test_backpressure();
    test_127_128();
    test_len5_flush();
    test_empty_flush();
    test_len_err();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
